door_motion_supervisor: RTL and testbench
=========================================

Name: door_motion_supervisor

Overview:
Supervisory sequencer for the garage door motor pair. Two command sources share one door: a wall button and a remote.
- Requests are merged and debounced into single command pulses.
- The block sequences open, close, stop and reverse, and enforces motor run timeouts, obstruction reversal, auto-close and reversal dead time.
- It sits between the user inputs and limit/safety sensors on one side and the motor drivers on the other.

Parameters:
TIMEOUT_CYC, 1000, maximum cycles any motor may run before FAULT
AUTOCLOSE_CYC, 5000, cycles in OPEN before automatic close
DEB_CYC, 4, consecutive high samples required to accept a button press
REVERSE_DLY, 2, motors-off cycles inserted before any direction start from STOPPED or reversal

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous active-low reset
Btn_Wall  in  1  wall push-button, raw level
Btn_Remote  in  1  remote receiver output, raw level
UP_Max  in  1  upper limit switch, 1 = fully open
DN_Max  in  1  lower limit switch, 1 = fully closed
Obstruct  in  1  safety beam blocked
UP_Motor  out  1  drive door up
DN_Motor  out  1  drive door down
Fault  out  1  sticky fault indicator
Door_State  out  3  current state code

Behaviour:
- Reset (RST low, asynchronous): state = CHECK, timer = 0, last_dir = UP, debouncer cleared. UP_Motor = DN_Motor = Fault = 0.
- Outputs are registered Moore decodes of state:
  - UP_Motor = 1 only in OPENING.
  - DN_Motor = 1 only in CLOSING.
  - Fault = 1 only in FAULT.
  - Never both motors = 1.
- Command: req = Btn_Wall | Btn_Remote.
  - Debounce counter increments while req = 1 and clears when req = 0.
  - A one-cycle cmd pulse fires on the cycle the count reaches DEB_CYC.
  - No further pulse until req has been sampled 0.
  - cmd affects state on the next rising edge.
- Timer: a single counter cleared on every state change. It increments in OPENING, CLOSING, OPEN and DEADTIME. In OPEN it is held at 0 while Obstruct = 1.
- Global: UP_Max & DN_Max in any state except CHECK → FAULT next cycle (highest priority).
- States and codes: CHECK 0, CLOSED 1, OPENING 2, OPEN 3, CLOSING 4, STOPPED 5, DEADTIME 6, FAULT 7.
- CHECK (one cycle):
  - DN_Max only → CLOSED.
  - UP_Max only → OPEN.
  - Both → FAULT.
  - Neither → STOPPED, with last_dir = UP so the next cmd closes.
- CLOSED: cmd → OPENING.
- OPENING (last_dir = UP), priority order:
  - UP_Max → OPEN.
  - timer == TIMEOUT_CYC-1 → FAULT.
  - cmd → STOPPED.
- OPEN:
  - cmd, or timer == AUTOCLOSE_CYC-1 with Obstruct = 0 → CLOSING.
  - cmd with Obstruct = 1 is ignored.
- CLOSING (last_dir = DN), priority order:
  - DN_Max → CLOSED.
  - Obstruct → DEADTIME with target UP.
  - timer == TIMEOUT_CYC-1 → FAULT.
  - cmd → STOPPED.
- STOPPED: cmd → DEADTIME with target = opposite of last_dir.
- DEADTIME: motors off for exactly REVERSE_DLY cycles, then → OPENING or CLOSING per target. cmd is ignored here.
- FAULT: sticky; exits only via reset.
- Simultaneous events:
  - DN_Max and Obstruct in CLOSING → CLOSED.
  - Limit and cmd in the same cycle → limit wins, and the cmd is consumed.
- Counter widths: $clog2 of the largest of TIMEOUT_CYC, AUTOCLOSE_CYC, REVERSE_DLY (plus 1). No wrap, because every terminal compare forces a state change.

Decomposition:
- Shared package door_pkg holds:
  - state code localparams (3-bit, values above);
  - direction constants DIR_UP = 0, DIR_DN = 1.
- One sub-module, door_btn_debounce (params DEB_CYC; in CLK, RST, raw; out cmd pulse), instantiated once on the OR-merged request.
- The FSM, timer and last_dir stay in the top.

Test Plan:
Bench uses TIMEOUT_CYC=20, AUTOCLOSE_CYC=30, DEB_CYC=3, REVERSE_DLY=2.
1. Reset with DN_Max=1, press Btn_Wall for 5 cycles → Door_State 0→1; cmd on 3rd high sample; UP_Motor=1 one cycle later. UP_Max raised at cycle 10 → Door_State=3, UP_Motor=0.
2. OPEN with no input → DN_Motor=1 exactly 30 cycles after OPEN entry. Obstruct=1 during OPEN holds the timer and delays the close by the obstruction length.
3. CLOSING, assert Obstruct → DN_Motor=0 next cycle, 2 cycles with both motors 0, then UP_Motor=1 (Door_State 4→6→2).
4. OPENING with no UP_Max for 20 cycles → Door_State=7, Fault=1, motors 0. Further presses have no effect; release RST → CHECK.
5. Btn_Remote press mid-CLOSING → STOPPED. Second press → DEADTIME for 2 cycles → OPENING. A 2-cycle glitch press produces no cmd.
6. UP_Max=DN_Max=1 asserted while OPEN → FAULT next cycle. Reset with neither limit then press → DEADTIME → CLOSING.

Source files
------------

// File: rtl/door_pkg.sv
// Shared definitions for the garage door supervisor: state codes, travel
// directions and a constant helper for sizing counters.
package door_pkg;

    typedef enum logic [2:0] {
        ST_CHECK    = 3'd0,
        ST_CLOSED   = 3'd1,
        ST_OPENING  = 3'd2,
        ST_OPEN     = 3'd3,
        ST_CLOSING  = 3'd4,
        ST_STOPPED  = 3'd5,
        ST_DEADTIME = 3'd6,
        ST_FAULT    = 3'd7
    } door_state_e;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/door_btn_debounce.sv
// Accepts a raw request level after DEB_CYC consecutive high samples and
// emits a single one-cycle cmd pulse per press.
module door_btn_debounce #(
    parameter int unsigned DEB_CYC = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic cmd
);

    localparam int unsigned   CW      = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          cmd_q, cmd_d;

    // Counter saturates at CNT_MAX so a held press cannot re-trigger.
    always_comb begin
        cnt_d = cnt_q;
        cmd_d = 1'b0;
        if (!raw) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
            cmd_d = (cnt_q == CNT_MAX - 1'b1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
            cmd_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            cmd_q <= cmd_d;
        end
    end

    assign cmd = cmd_q;

endmodule

// File: rtl/door_motion_supervisor.sv
// Garage door sequencer: merges wall/remote requests, drives the up/down
// motors, and enforces timeouts, obstruction reversal, auto-close and dead time.
module door_motion_supervisor
    import door_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC   = 1000,
    parameter int unsigned AUTOCLOSE_CYC = 5000,
    parameter int unsigned DEB_CYC       = 4,
    parameter int unsigned REVERSE_DLY   = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Btn_Wall,
    input  logic       Btn_Remote,
    input  logic       UP_Max,
    input  logic       DN_Max,
    input  logic       Obstruct,
    output logic       UP_Motor,
    output logic       DN_Motor,
    output logic       Fault,
    output logic [2:0] Door_State
);

    localparam int unsigned   TW          = $clog2(max3(TIMEOUT_CYC, AUTOCLOSE_CYC, REVERSE_DLY) + 1);
    localparam logic [TW-1:0] T_TIMEOUT   = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] T_AUTOCLOSE = TW'(AUTOCLOSE_CYC - 1);
    localparam logic [TW-1:0] T_DEAD      = TW'(REVERSE_DLY - 1);

    door_state_e   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          last_dir_q, last_dir_d;
    logic          target_q, target_d;
    logic          up_q, dn_q, fault_q;
    logic          req, cmd;

    assign req = Btn_Wall | Btn_Remote;

    door_btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
        .CLK (CLK),
        .RST (RST),
        .raw (req),
        .cmd (cmd)
    );

    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        target_d   = target_q;
        case (state_q)
            ST_CHECK: begin
                if (UP_Max && DN_Max)  state_d = ST_FAULT;
                else if (DN_Max)       state_d = ST_CLOSED;
                else if (UP_Max)       state_d = ST_OPEN;
                else begin
                    state_d    = ST_STOPPED;
                    last_dir_d = DIR_UP;
                end
            end
            ST_CLOSED:
                if (cmd) state_d = ST_OPENING;
            ST_OPENING: begin
                if (UP_Max)                    state_d = ST_OPEN;
                else if (timer_q == T_TIMEOUT) state_d = ST_FAULT;
                else if (cmd)                  state_d = ST_STOPPED;
            end
            ST_OPEN:
                if ((cmd || timer_q == T_AUTOCLOSE) && !Obstruct) state_d = ST_CLOSING;
            ST_CLOSING: begin
                if (DN_Max) state_d = ST_CLOSED;
                else if (Obstruct) begin
                    state_d  = ST_DEADTIME;
                    target_d = DIR_UP;
                end
                else if (timer_q == T_TIMEOUT) state_d = ST_FAULT;
                else if (cmd)                  state_d = ST_STOPPED;
            end
            ST_STOPPED: begin
                if (cmd) begin
                    state_d  = ST_DEADTIME;
                    target_d = ~last_dir_q;
                end
            end
            ST_DEADTIME:
                if (timer_q == T_DEAD) state_d = (target_q == DIR_UP) ? ST_OPENING : ST_CLOSING;
            ST_FAULT: ;
            default:  state_d = ST_FAULT;
        endcase

        // Conflicting limit switches override every transition above.
        if (state_q != ST_CHECK && UP_Max && DN_Max) state_d = ST_FAULT;

        if (state_d == ST_OPENING) last_dir_d = DIR_UP;
        if (state_d == ST_CLOSING) last_dir_d = DIR_DN;
    end

    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else begin
            case (state_q)
                ST_OPENING, ST_CLOSING, ST_DEADTIME: timer_d = timer_q + 1'b1;
                ST_OPEN:  timer_d = Obstruct ? '0 : timer_q + 1'b1;
                default:  timer_d = timer_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_CHECK;
            timer_q    <= '0;
            last_dir_q <= DIR_UP;
            target_q   <= DIR_UP;
            up_q       <= 1'b0;
            dn_q       <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            last_dir_q <= last_dir_d;
            target_q   <= target_d;
            up_q       <= (state_d == ST_OPENING);
            dn_q       <= (state_d == ST_CLOSING);
            fault_q    <= (state_d == ST_FAULT);
        end
    end

    assign UP_Motor   = up_q;
    assign DN_Motor   = dn_q;
    assign Fault      = fault_q;
    assign Door_State = state_q;

endmodule

// File: tb/tb_door_motion_supervisor.sv
// Self-checking bench for door_motion_supervisor: per-cycle stimulus with
// expected outputs queued on drive and compared one cycle later.
module tb_door_motion_supervisor;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Btn_Wall = 1'b0, Btn_Remote = 1'b0;
    logic       UP_Max = 1'b0, DN_Max = 1'b0, Obstruct = 1'b0;
    logic       UP_Motor, DN_Motor, Fault;
    logic [2:0] Door_State;

    int tests = 0;
    int fails = 0;

    // Inputs {wall, remote, up_max, dn_max, obstruct}
    localparam logic [4:0] I_NONE = 5'b00000;
    localparam logic [4:0] I_W    = 5'b10000;
    localparam logic [4:0] I_R    = 5'b01000;
    localparam logic [4:0] I_UP   = 5'b00100;
    localparam logic [4:0] I_DN   = 5'b00010;
    localparam logic [4:0] I_OB   = 5'b00001;

    // Expected {state[2:0], up_motor, dn_motor, fault}
    localparam logic [5:0] E_CHECK   = 6'b000_000;
    localparam logic [5:0] E_CLOSED  = 6'b001_000;
    localparam logic [5:0] E_OPENING = 6'b010_100;
    localparam logic [5:0] E_OPEN    = 6'b011_000;
    localparam logic [5:0] E_CLOSING = 6'b100_010;
    localparam logic [5:0] E_STOPPED = 6'b101_000;
    localparam logic [5:0] E_DEAD    = 6'b110_000;
    localparam logic [5:0] E_FAULT   = 6'b111_001;

    typedef struct packed {
        logic [4:0] in;
        logic [5:0] ex;
    } vec_t;

    logic [5:0] sb[$];
    vec_t       t1[11];

    door_motion_supervisor #(
        .TIMEOUT_CYC   (20),
        .AUTOCLOSE_CYC (30),
        .DEB_CYC       (3),
        .REVERSE_DLY   (2)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Btn_Wall   (Btn_Wall),
        .Btn_Remote (Btn_Remote),
        .UP_Max     (UP_Max),
        .DN_Max     (DN_Max),
        .Obstruct   (Obstruct),
        .UP_Motor   (UP_Motor),
        .DN_Motor   (DN_Motor),
        .Fault      (Fault),
        .Door_State (Door_State)
    );

    always #5 CLK = ~CLK;

    task automatic compare(input string name, input logic [5:0] e);
        logic [5:0] act;
        act = {Door_State, UP_Motor, DN_Motor, Fault};
        tests++;
        if (act !== e) begin
            fails++;
            $display("FAIL %s @%0t: got state=%0d up=%b dn=%b fault=%b, expected state=%0d up=%b dn=%b fault=%b",
                     name, $time, act[5:3], act[2], act[1], act[0], e[5:3], e[2], e[1], e[0]);
        end
    endtask

    task automatic step(input string name, input logic [4:0] in, input logic [5:0] ex);
        {Btn_Wall, Btn_Remote, UP_Max, DN_Max, Obstruct} = in;
        sb.push_back(ex);
        @(posedge CLK);
        #1;
        compare(name, sb.pop_front());
    endtask

    task automatic do_reset(input logic up, input logic dn);
        @(negedge CLK);
        {Btn_Wall, Btn_Remote, Obstruct} = 3'b000;
        UP_Max = up;
        DN_Max = dn;
        RST = 1'b0;
        #1;
        compare("reset_state", E_CHECK);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        t1 = '{
            {I_DN,       E_CLOSED},
            {I_W | I_DN, E_CLOSED},
            {I_W | I_DN, E_CLOSED},
            {I_W | I_DN, E_CLOSED},
            {I_W,        E_OPENING},
            {I_W,        E_OPENING},
            {I_NONE,     E_OPENING},
            {I_NONE,     E_OPENING},
            {I_NONE,     E_OPENING},
            {I_NONE,     E_OPENING},
            {I_UP,       E_OPEN}
        };

        do_reset(1'b0, 1'b1);
        for (int i = 0; i < 11; i++) step("open_from_closed", t1[i].in, t1[i].ex);

        for (int i = 1; i < 30; i++) step("autoclose_wait", I_UP, E_OPEN);
        step("autoclose_fire", I_UP, E_CLOSING);

        step("obstruct_reverse", I_OB,   E_DEAD);
        step("deadtime_hold",    I_NONE, E_DEAD);
        step("deadtime_exit",    I_NONE, E_OPENING);
        step("opening",          I_NONE, E_OPENING);
        step("reach_open",       I_UP,   E_OPEN);

        for (int i = 0; i < 4; i++) step("open_cmd_obstructed", I_UP | I_OB | I_W, E_OPEN);
        step("open_obstructed", I_UP | I_OB, E_OPEN);
        for (int i = 0; i < 29; i++) step("open_delayed", I_UP, E_OPEN);
        step("delayed_close", I_NONE, E_CLOSING);

        for (int i = 0; i < 3; i++) step("remote_press", I_R, E_CLOSING);
        step("remote_stop",  I_R,    E_STOPPED);
        step("stopped_idle", I_NONE, E_STOPPED);
        for (int i = 0; i < 2; i++) step("glitch", I_R, E_STOPPED);
        for (int i = 0; i < 3; i++) step("glitch_ignored", I_NONE, E_STOPPED);
        for (int i = 0; i < 3; i++) step("second_press", I_R, E_STOPPED);
        step("reverse_dead1", I_NONE, E_DEAD);
        step("reverse_dead2", I_NONE, E_DEAD);
        step("reverse_open",  I_NONE, E_OPENING);

        for (int i = 0; i < 19; i++) step("opening_run", I_NONE, E_OPENING);
        step("opening_timeout", I_NONE, E_FAULT);
        for (int i = 0; i < 5; i++) step("fault_sticky", I_W, E_FAULT);

        do_reset(1'b1, 1'b0);
        step("check_to_open", I_UP,        E_OPEN);
        step("both_limits",   I_UP | I_DN, E_FAULT);

        do_reset(1'b0, 1'b0);
        step("check_to_stopped", I_NONE, E_STOPPED);
        for (int i = 0; i < 3; i++) step("press_from_check", I_W, E_STOPPED);
        step("dead_a",      I_NONE, E_DEAD);
        step("dead_b",      I_NONE, E_DEAD);
        step("close_start", I_NONE, E_CLOSING);
        step("dn_and_obstruct", I_DN | I_OB, E_CLOSED);

        for (int i = 0; i < 3; i++) step("closed_press", I_W | I_DN, E_CLOSED);
        step("closed_to_opening", I_DN, E_OPENING);
        for (int i = 0; i < 3; i++) step("opening_press", I_W, E_OPENING);
        step("limit_wins_cmd", I_UP, E_OPEN);
        step("cmd_consumed",   I_UP, E_OPEN);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
